// File: rtl/can_frame_sequencer.sv
// Avalon-MM master that configures an SJA1000-style CAN controller (BasicCAN), launches TX frames and drains RX frames on interrupt.
// Optional bus-access watchdog enabled by defining CAN_SEQ_TIMEOUT_EN.
module can_frame_sequencer #(
  parameter logic [7:0]  CLKDIV   = 8'h07,
  parameter logic [7:0]  ACC_CODE = 8'h00,
  parameter logic [7:0]  ACC_MASK = 8'hFF,
  parameter logic [7:0]  BTR0     = 8'h00,
  parameter logic [7:0]  BTR1     = 8'h14,
  parameter logic [7:0]  OCR      = 8'h1A,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        av_clk,
  input  logic        av_reset_n,
  output logic [7:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest_n,
  input  logic        can_irq_n,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        init_done,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_TX_LOAD, S_TX_CMD, S_IRQ_RD, S_RX_RD, S_RX_HOLD, S_RX_REL
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_step, w_step_nxt;
  logic        r_strobe, r_we;
  logic [7:0]  r_addr, r_wbyte;
  logic        r_init_done, r_tx_busy, r_tx_done, r_rx_valid;
  logic [10:0] r_tx_id;
  logic        r_tx_rtr;
  logic [3:0]  r_tx_dlc;
  logic [63:0] r_tx_data;
  logic [79:0] r_rx_buf;

  logic        w_done, w_tmo, w_launch, w_acc_req, w_acc_rd, w_tx_fire;
  logic [7:0]  w_acc_addr, w_acc_wdata, w_tx_byte, w_rd_byte;
  logic [3:0]  w_tx_nbytes;
  logic [2:0]  w_byte_idx;

  assign w_done      = r_strobe & m_waitrequest_n;
  assign w_launch    = ~r_strobe & w_acc_req;
  assign w_rd_byte   = m_readdata[7:0];
  assign w_tx_nbytes = r_tx_rtr ? 4'd0 : ((r_tx_dlc > 4'd8) ? 4'd8 : r_tx_dlc);
  assign w_byte_idx  = 3'(r_step - 4'd2);
  assign w_tx_byte   = r_tx_data[{3'd7 - w_byte_idx, 3'b111} -: 8];
  assign tx_ready    = (r_state == S_IDLE) & r_init_done & ~r_tx_busy & can_irq_n;
  assign w_tx_fire   = tx_valid & tx_ready;

  // Register address / write data for the access the current state performs
  always_comb begin
    w_acc_req   = 1'b1;
    w_acc_rd    = 1'b0;
    w_acc_addr  = '0;
    w_acc_wdata = '0;
    case (r_state)
      S_INIT: begin
        case (r_step)
          4'd0:    begin w_acc_addr = 8'd0;  w_acc_wdata = 8'h01;    end
          4'd1:    begin w_acc_addr = 8'd31; w_acc_wdata = CLKDIV;   end
          4'd2:    begin w_acc_addr = 8'd4;  w_acc_wdata = ACC_CODE; end
          4'd3:    begin w_acc_addr = 8'd5;  w_acc_wdata = ACC_MASK; end
          4'd4:    begin w_acc_addr = 8'd6;  w_acc_wdata = BTR0;     end
          4'd5:    begin w_acc_addr = 8'd7;  w_acc_wdata = BTR1;     end
          4'd6:    begin w_acc_addr = 8'd8;  w_acc_wdata = OCR;      end
          default: begin w_acc_addr = 8'd0;  w_acc_wdata = 8'h06;    end
        endcase
      end
      S_TX_LOAD: begin
        if (r_step == 4'd0) begin
          w_acc_addr = 8'd10; w_acc_wdata = r_tx_id[10:3];
        end else if (r_step == 4'd1) begin
          w_acc_addr = 8'd11; w_acc_wdata = {r_tx_id[2:0], r_tx_rtr, r_tx_dlc};
        end else begin
          w_acc_addr = 8'd10 + {4'd0, r_step}; w_acc_wdata = w_tx_byte;
        end
      end
      S_TX_CMD: begin w_acc_addr = 8'd1; w_acc_wdata = 8'h01; end
      S_IRQ_RD: begin w_acc_addr = 8'd3; w_acc_rd = 1'b1; end
      S_RX_RD:  begin w_acc_addr = 8'd20 + {4'd0, r_step}; w_acc_rd = 1'b1; end
      S_RX_REL: begin w_acc_addr = 8'd1; w_acc_wdata = 8'h04; end
      default:  w_acc_req = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      S_INIT:
        if (w_done) begin
          if (r_step == 4'd7) begin w_state_nxt = S_IDLE; w_step_nxt = '0; end
          else w_step_nxt = r_step + 4'd1;
        end
      S_IDLE:
        if (!r_init_done) begin w_state_nxt = S_INIT; w_step_nxt = '0; end
        else if (!can_irq_n) w_state_nxt = S_IRQ_RD;
        else if (w_tx_fire) begin w_state_nxt = S_TX_LOAD; w_step_nxt = '0; end
      S_TX_LOAD:
        if (w_done) begin
          if (r_step == 4'd1 + w_tx_nbytes) begin w_state_nxt = S_TX_CMD; w_step_nxt = '0; end
          else w_step_nxt = r_step + 4'd1;
        end
      S_TX_CMD: if (w_done) w_state_nxt = S_IDLE;
      S_IRQ_RD:
        if (w_done) begin
          w_state_nxt = w_rd_byte[0] ? S_RX_RD : S_IDLE;
          w_step_nxt  = '0;
        end
      S_RX_RD:
        if (w_done) begin
          if (r_step == 4'd9) begin w_state_nxt = S_RX_HOLD; w_step_nxt = '0; end
          else w_step_nxt = r_step + 4'd1;
        end
      S_RX_HOLD: if (r_rx_valid && rx_ready) w_state_nxt = S_RX_REL;
      S_RX_REL:  if (w_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_INIT;
    endcase
    if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_step_nxt  = '0;
    end
  end

  always_ff @(posedge av_clk or negedge av_reset_n) begin
    if (!av_reset_n) begin
      r_state <= S_INIT;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_ff @(posedge av_clk or negedge av_reset_n) begin
    if (!av_reset_n) begin
      r_strobe    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wbyte     <= '0;
      r_init_done <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_tx_id     <= '0;
      r_tx_rtr    <= 1'b0;
      r_tx_dlc    <= '0;
      r_tx_data   <= '0;
      r_rx_buf    <= '0;
    end else begin
      r_tx_done <= 1'b0;
      if (w_launch) begin
        r_strobe <= 1'b1;
        r_we     <= ~w_acc_rd;
        r_addr   <= w_acc_addr;
        r_wbyte  <= w_acc_wdata;
      end
      if (w_done) begin
        r_strobe <= 1'b0;
        case (r_state)
          S_INIT:   if (r_step == 4'd7) r_init_done <= 1'b1;
          S_TX_CMD: r_tx_busy <= 1'b1;
          S_IRQ_RD:
            if (w_rd_byte[1]) begin
              r_tx_busy <= 1'b0;
              r_tx_done <= 1'b1;
            end
          // Bytes 20..29 shift in so byte 20 ends up in the top octet
          S_RX_RD: begin
            r_rx_buf <= {r_rx_buf[71:0], w_rd_byte};
            if (r_step == 4'd9) r_rx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (w_tmo) begin
        r_strobe  <= 1'b0;
        r_tx_busy <= 1'b0;
      end
      if (w_tx_fire) begin
        r_tx_id   <= tx_id;
        r_tx_rtr  <= tx_rtr;
        r_tx_dlc  <= tx_dlc;
        r_tx_data <= tx_data;
      end
      if (r_state == S_RX_HOLD && r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
    end
  end

`ifdef CAN_SEQ_TIMEOUT_EN
  logic [15:0] r_tcnt;
  logic        r_bus_err;

  always_ff @(posedge av_clk or negedge av_reset_n) begin
    if (!av_reset_n) begin
      r_tcnt    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (!r_strobe || m_waitrequest_n) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + 16'd1;
      if (w_tmo) r_bus_err <= 1'b1;
    end
  end

  assign w_tmo   = r_strobe & ~m_waitrequest_n & (r_tcnt == TIMEOUT - 16'd1);
  assign bus_err = r_bus_err;
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{m_readdata[31:8], TIMEOUT};

  assign m_chipselect = r_strobe;
  assign m_write      = r_strobe & r_we;
  assign m_read       = r_strobe & ~r_we;
  assign m_address    = r_addr;
  assign m_writedata  = {24'h0, r_wbyte};
  assign m_byteenable = r_strobe ? 4'b0001 : 4'b0000;
  assign init_done    = r_init_done;
  assign tx_busy      = r_tx_busy;
  assign tx_done      = r_tx_done;
  assign rx_valid     = r_rx_valid;
  assign rx_id        = {r_rx_buf[79:72], r_rx_buf[71:69]};
  assign rx_rtr       = r_rx_buf[68];
  assign rx_dlc       = r_rx_buf[67:64];
  assign rx_data      = r_rx_buf[63:0];

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Self-checking bench: Avalon slave model with register image, access log and frame-level reference model.
module tb_can_frame_sequencer;

  logic        av_clk, av_reset_n;
  logic [7:0]  m_address;
  logic        m_chipselect, m_write, m_read;
  logic [31:0] m_writedata, m_readdata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest_n, can_irq_n;
  logic        tx_valid, tx_ready, tx_rtr;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        rx_valid, rx_ready, rx_rtr;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        init_done, tx_busy, tx_done, bus_err;

  can_frame_sequencer #(.TIMEOUT(16'd16)) dut (
    .av_clk(av_clk), .av_reset_n(av_reset_n),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write), .m_read(m_read),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_byteenable(m_byteenable),
    .m_waitrequest_n(m_waitrequest_n), .can_irq_n(can_irq_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_rtr(tx_rtr),
    .tx_dlc(tx_dlc), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_id(rx_id), .rx_rtr(rx_rtr),
    .rx_dlc(rx_dlc), .rx_data(rx_data),
    .init_done(init_done), .tx_busy(tx_busy), .tx_done(tx_done), .bus_err(bus_err)
  );

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [7:0]  data;
    int unsigned gap;
  } acc_t;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  logic [7:0]  mem [256];
  int unsigned n_chk, n_fail;
  int unsigned lat, txdone_cnt, strobe_cyc;
  bit          hold;

  initial av_clk = 1'b0;
  always #5 av_clk = ~av_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Avalon slave: acks after lat cycles (lat==0 means random 1..3), logs every completed access
  initial begin : slave
    int unsigned cnt, tgt, gap;
    logic [7:0]  s_addr, s_wd;
    logic        s_we;
    bit          stable;
    cnt = 0; tgt = 1; gap = 0; stable = 1; s_addr = '0; s_wd = '0; s_we = 1'b0;
    m_waitrequest_n = 1'b0;
    m_readdata = '0;
    forever begin
      @(negedge av_clk);
      if (tx_done === 1'b1) txdone_cnt++;
      if (m_chipselect === 1'b1) begin
        strobe_cyc++;
        if (cnt == 0) begin
          s_addr = m_address; s_wd = m_writedata[7:0]; s_we = m_write; stable = 1;
          tgt = (lat == 0) ? $urandom_range(1, 3) : lat;
        end else if (m_address !== s_addr || m_writedata[7:0] !== s_wd || m_write !== s_we) begin
          stable = 0;
        end
        cnt++;
        if (!hold && cnt >= tgt) begin
          m_waitrequest_n = 1'b1;
          m_readdata = {24'($urandom), mem[m_address]};
          log_q.push_back('{m_write, m_address, (m_write ? m_writedata[7:0] : mem[m_address]), gap});
          gap = 0;
          n_chk++;
          if (!stable || m_byteenable !== 4'b0001 || m_read !== ~m_write || m_writedata[31:8] !== 24'h0) begin
            n_fail++;
            $display("FAIL bus_protocol: addr=%h be=%b rd=%b wr=%b wd=%h stable=%0d, required be=0001, one strobe, held fields",
                     m_address, m_byteenable, m_read, m_write, m_writedata, stable);
          end
          if (!m_write && m_address == 8'd3) can_irq_n = 1'b1;
        end else begin
          m_waitrequest_n = 1'b0;
        end
      end else begin
        m_waitrequest_n = 1'b0;
        cnt = 0;
        gap++;
      end
    end
  end

  task automatic wait_log(input int unsigned n, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (log_q.size() >= n) begin ok = 1; break; end
      @(negedge av_clk);
    end
  endtask

  // Reference: register writes the controller needs for one TX frame
  task automatic model_tx(input logic [10:0] id, input logic rtr, input logic [3:0] dlc, input logic [63:0] data);
    int unsigned nb;
    logic [63:0] t;
    exp_q.delete();
    nb = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    exp_q.push_back('{1, 8'd10, id[10:3], 0});
    exp_q.push_back('{1, 8'd11, {id[2:0], rtr, dlc}, 0});
    for (int k = 0; k < int'(nb); k++) begin
      t = data << (8 * k);
      exp_q.push_back('{1, 8'(12 + k), t[63:56], 0});
    end
    exp_q.push_back('{1, 8'd1, 8'h01, 0});
  endtask

  task automatic test_reset();
    av_reset_n = 1'b0;
    tx_valid = 0; tx_id = '0; tx_rtr = 0; tx_dlc = '0; tx_data = '0;
    rx_ready = 0; can_irq_n = 1'b1; hold = 0; lat = 2;
    repeat (3) @(negedge av_clk);
    n_chk++;
    if ({m_address, m_chipselect, m_write, m_read, m_writedata, m_byteenable, tx_ready, rx_valid,
         rx_id, rx_rtr, rx_dlc, rx_data, init_done, tx_busy, tx_done, bus_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr=%h cs=%b wd=%h rxv=%b init=%b busy=%b, required all zero",
               m_address, m_chipselect, m_writedata, rx_valid, init_done, tx_busy);
    end
    log_q.delete();
    av_reset_n = 1'b1;
  endtask

  task automatic test_init(input string tag);
    logic [7:0] ea [8] = '{8'd0, 8'd31, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd0};
    logic [7:0] ed [8] = '{8'h01, 8'h07, 8'h00, 8'hFF, 8'h00, 8'h14, 8'h1A, 8'h06};
    bit ok;
    wait_log(8, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_timeout: got %0d accesses, required 8", tag, log_q.size()); return; end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if ({log_q[i].we, log_q[i].addr, log_q[i].data} !== {1'b1, ea[i], ed[i]} || (i > 0 && log_q[i].gap != 1)) begin
        n_fail++;
        $display("FAIL %s_write%0d: got we=%0d %0d:%h gap=%0d, required write %0d:%h gap=1",
                 tag, i, log_q[i].we, log_q[i].addr, log_q[i].data, log_q[i].gap, ea[i], ed[i]);
      end
    end
    repeat (3) @(negedge av_clk);
    n_chk++;
    if (init_done !== 1'b1 || tx_ready !== 1'b1 || log_q.size() != 8) begin
      n_fail++;
      $display("FAIL %s_done: init_done=%b tx_ready=%b accesses=%0d, required 1 1 8", tag, init_done, tx_ready, log_q.size());
    end
  endtask

  task automatic test_tx(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input bit do_irq, input string tag);
    int unsigned base, d0;
    bit ok, acc;
    model_tx(id, rtr, dlc, data);
    base = log_q.size();
    tx_valid = 1; tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready === 1'b1) begin @(posedge av_clk); #1; acc = 1; break; end
      @(negedge av_clk);
    end
    tx_valid = 0; tx_id = 11'($urandom); tx_rtr = 1'($urandom); tx_dlc = 4'($urandom); tx_data = {$urandom, $urandom};
    n_chk++;
    if (!acc) begin n_fail++; $display("FAIL %s_handshake: tx_ready=%b, required handshake", tag, tx_ready); return; end
    wait_log(base + exp_q.size(), ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL %s_writes: got %0d, required %0d", tag, log_q.size() - base, exp_q.size()); return; end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data} !== {exp_q[i].we, exp_q[i].addr, exp_q[i].data}
          || (i > 0 && log_q[base+i].gap != 1)) begin
        n_fail++;
        $display("FAIL %s_write%0d: got we=%0d %0d:%h gap=%0d, required %0d:%h gap=1", tag, i,
                 log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data, log_q[base+i].gap, exp_q[i].addr, exp_q[i].data);
      end
    end
    repeat (2) @(negedge av_clk);
    n_chk++;
    if (tx_busy !== 1'b1 || tx_ready !== 1'b0 || log_q.size() != base + exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_busy: tx_busy=%b tx_ready=%b extra=%0d, required 1 0 0", tag, tx_busy, tx_ready,
               log_q.size() - base - exp_q.size());
    end
    if (!do_irq) return;
    base = log_q.size();
    d0 = txdone_cnt;
    mem[3] = 8'h02 | 8'($urandom & 32'hFC & ~32'h01);
    can_irq_n = 1'b0;
    wait_log(base + 1, ok);
    repeat (3) @(negedge av_clk);
    n_chk++;
    if (!ok || log_q[base].we || log_q[base].addr !== 8'd3 || txdone_cnt - d0 != 1 || tx_busy !== 1'b0 || log_q.size() != base + 1) begin
      n_fail++;
      $display("FAIL %s_ti: ok=%0d done_cycles=%0d tx_busy=%b accesses=%0d, required read 3, 1 pulse, busy 0, 1 access",
               tag, ok, txdone_cnt - d0, tx_busy, log_q.size() - base);
    end
  endtask

  // Controller register image for an RX frame; returns the frame fields to expect
  task automatic load_rx(input bit directed, output logic [10:0] id, output logic rtr,
                         output logic [3:0] dlc, output logic [63:0] data);
    logic [63:0] t;
    if (directed) begin
      id = 11'h123; rtr = 0; dlc = 4'd3; data = 64'hAABBCCDDEEFF0011;
    end else begin
      id = 11'($urandom); rtr = 1'($urandom); dlc = 4'($urandom); data = {$urandom, $urandom};
    end
    mem[20] = id[10:3];
    mem[21] = {id[2:0], rtr, dlc};
    for (int k = 0; k < 8; k++) begin
      t = data << (8 * k);
      mem[22 + k] = t[63:56];
    end
  endtask

  task automatic test_rx(input bit directed, input string tag);
    logic [10:0] id; logic rtr; logic [3:0] dlc; logic [63:0] data;
    int unsigned base, d0;
    bit ok, seen, stable;
    load_rx(directed, id, rtr, dlc, data);
    mem[3] = 8'h01;
    base = log_q.size();
    d0 = txdone_cnt;
    can_irq_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge av_clk);
      if (rx_valid === 1'b1) begin seen = 1; break; end
    end
    n_chk++;
    if (!seen || {rx_id, rx_rtr, rx_dlc, rx_data} !== {id, rtr, dlc, data}) begin
      n_fail++;
      $display("FAIL %s_fields: valid=%b id=%h rtr=%b dlc=%h data=%h, required id=%h rtr=%b dlc=%h data=%h",
               tag, rx_valid, rx_id, rx_rtr, rx_dlc, rx_data, id, rtr, dlc, data);
    end
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge av_clk);
      if (rx_valid !== 1'b1 || {rx_id, rx_rtr, rx_dlc, rx_data} !== {id, rtr, dlc, data}) stable = 0;
    end
    n_chk++;
    if (!stable || log_q.size() != base + 11) begin
      n_fail++;
      $display("FAIL %s_hold: stable=%0d accesses=%0d, required stable with 11 accesses", tag, stable, log_q.size() - base);
    end
    rx_ready = 1;
    @(negedge av_clk);
    rx_ready = 0;
    n_chk++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drop: rx_valid=%b, required 0", tag, rx_valid); end
    wait_log(base + 12, ok);
    repeat (3) @(negedge av_clk);
    n_chk++;
    if (!ok || log_q.size() != base + 12 || txdone_cnt != d0) begin
      n_fail++;
      $display("FAIL %s_count: accesses=%0d tx_done_cycles=%0d, required 12 and 0", tag, log_q.size() - base, txdone_cnt - d0);
      return;
    end
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (i == 0 ? (log_q[base].we || log_q[base].addr !== 8'd3) :
          i == 11 ? (!log_q[base+i].we || log_q[base+i].addr !== 8'd1 || log_q[base+i].data !== 8'h04) :
          (log_q[base+i].we || log_q[base+i].addr !== 8'(19 + i) || log_q[base+i].gap != 1)) begin
        n_fail++;
        $display("FAIL %s_access%0d: got we=%0d addr=%0d data=%h gap=%0d", tag, i,
                 log_q[base+i].we, log_q[base+i].addr, log_q[base+i].data, log_q[base+i].gap);
      end
    end
  endtask

  // TI and RI together with a pending tx: TI handled, RX drained, then the frame is accepted
  task automatic test_irq_tx_rx();
    logic [10:0] id; logic rtr; logic [3:0] dlc; logic [63:0] data;
    logic [10:0] fid; logic [3:0] fdlc; logic [63:0] fdata;
    int unsigned base, d0;
    bit ok, seen, held, acc;
    test_tx(11'($urandom), 1'b0, 4'($urandom_range(0, 8)), {$urandom, $urandom}, 1'b0, "mix_prime");
    load_rx(1'b0, id, rtr, dlc, data);
    fid = 11'($urandom); fdlc = 4'($urandom_range(1, 8)); fdata = {$urandom, $urandom};
    mem[3] = 8'h03;
    base = log_q.size();
    d0 = txdone_cnt;
    can_irq_n = 1'b0;
    tx_valid = 1; tx_id = fid; tx_rtr = 0; tx_dlc = fdlc; tx_data = fdata;
    seen = 0; held = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge av_clk);
      if (tx_ready !== 1'b0) held = 0;
      if (rx_valid === 1'b1) begin seen = 1; break; end
    end
    n_chk++;
    if (!seen || !held || txdone_cnt - d0 != 1 || tx_busy !== 1'b0 || {rx_id, rx_rtr, rx_dlc, rx_data} !== {id, rtr, dlc, data}) begin
      n_fail++;
      $display("FAIL mix_rx: seen=%0d tx_held=%0d done_cycles=%0d busy=%b id=%h, required 1 1 1 0 id=%h",
               seen, held, txdone_cnt - d0, tx_busy, rx_id, id);
    end
    rx_ready = 1;
    @(negedge av_clk);
    rx_ready = 0;
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready === 1'b1) begin @(posedge av_clk); #1; acc = 1; break; end
      @(negedge av_clk);
    end
    tx_valid = 0;
    model_tx(fid, 1'b0, fdlc, fdata);
    wait_log(base + 12 + exp_q.size(), ok);
    n_chk++;
    if (!acc || !ok) begin
      n_fail++;
      $display("FAIL mix_tx_accept: accepted=%0d accesses=%0d, required accept and %0d", acc, log_q.size() - base, 12 + exp_q.size());
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({log_q[base+12+i].we, log_q[base+12+i].addr, log_q[base+12+i].data} !== {exp_q[i].we, exp_q[i].addr, exp_q[i].data}) begin
        n_fail++;
        $display("FAIL mix_write%0d: got %0d:%h, required %0d:%h", i, log_q[base+12+i].addr, log_q[base+12+i].data,
                 exp_q[i].addr, exp_q[i].data);
      end
    end
    n_chk++;
    if (log_q[base+11].we !== 1'b1 || log_q[base+11].addr !== 8'd1 || log_q[base+11].data !== 8'h04) begin
      n_fail++;
      $display("FAIL mix_release: got %0d:%h, required 1:04 before tx load", log_q[base+11].addr, log_q[base+11].data);
    end
    base = log_q.size();
    d0 = txdone_cnt;
    repeat (2) @(negedge av_clk);
    mem[3] = 8'h02;
    can_irq_n = 1'b0;
    wait_log(base + 1, ok);
    repeat (3) @(negedge av_clk);
    n_chk++;
    if (!ok || tx_busy !== 1'b0 || txdone_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL mix_final_ti: tx_busy=%b done_cycles=%0d, required 0 and 1", tx_busy, txdone_cnt - d0);
    end
  endtask

  task automatic test_timeout();
`ifdef CAN_SEQ_TIMEOUT_EN
    bit seen, dropped;
    hold = 1;
    strobe_cyc = 0;
    mem[3] = 8'h00;
    can_irq_n = 1'b0;
    seen = 0; dropped = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge av_clk);
      if (m_chipselect === 1'b1) seen = 1;
      else if (seen) begin dropped = 1; break; end
    end
    can_irq_n = 1'b1;
    hold = 0;
    n_chk++;
    if (!dropped || strobe_cyc != 16 || bus_err !== 1'b1 || m_read !== 1'b0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: dropped=%0d strobe_cycles=%0d bus_err=%b busy=%b, required 1 16 1 0",
               dropped, strobe_cyc, bus_err, tx_busy);
    end
`else
    n_chk++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL bus_err_tied: got %b, required 0", bus_err); end
`endif
  endtask

  task automatic test_reset_mid_tx();
    int unsigned base;
    bit ok, acc, seen;
    base = log_q.size();
    tx_valid = 1; tx_id = 11'($urandom); tx_rtr = 0; tx_dlc = 4'd8; tx_data = {$urandom, $urandom};
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx_ready === 1'b1) begin @(posedge av_clk); #1; acc = 1; break; end
      @(negedge av_clk);
    end
    tx_valid = 0;
    wait_log(base + 3, ok);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_chipselect === 1'b1) begin seen = 1; break; end
      @(negedge av_clk);
    end
    #2 av_reset_n = 1'b0;
    #1;
    n_chk++;
    if (!acc || !ok || !seen || {m_chipselect, m_write, m_read, m_address, m_writedata, m_byteenable,
         init_done, tx_busy, tx_ready, rx_valid, rx_id, rx_data} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: acc=%0d ok=%0d seen=%0d cs=%b wr=%b addr=%h init=%b, required all zero",
               acc, ok, seen, m_chipselect, m_write, m_address, init_done);
    end
    repeat (2) @(negedge av_clk);
    log_q.delete();
    lat = 2;
    av_reset_n = 1'b1;
    test_init("reinit");
  endtask

  initial begin
    n_chk = 0; n_fail = 0; txdone_cnt = 0; strobe_cyc = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_init("init");
    lat = 0;
    test_tx(11'h123, 1'b0, 4'd3, 64'hAABBCCDDEEFF0011, 1'b1, "tx_directed");
    test_tx(11'($urandom), 1'b1, 4'd8, {$urandom, $urandom}, 1'b1, "tx_rtr");
    test_tx(11'($urandom), 1'b0, 4'hF, {$urandom, $urandom}, 1'b1, "tx_dlc15");
    for (int n = 0; n < 6; n++)
      test_tx(11'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom), {$urandom, $urandom}, 1'b1, "tx_rand");
    test_rx(1'b1, "rx_directed");
    for (int n = 0; n < 4; n++) test_rx(1'b0, "rx_rand");
    test_irq_tx_rx();
    test_timeout();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/can_frame_sequencer.md
Name: can_frame_sequencer

Overview:
- Avalon-MM master sitting in front of the Avalon control port of the SJA1000-compatible CAN controller wrapper (8-bit registers on writedata/readdata[7:0]).
- After reset, programs the controller in BasicCAN mode.
- Then loads and launches TX frames from a valid/ready frame interface.
- Services the controller interrupt, draining RX frames to a valid/ready output and releasing the receive buffer.

Parameters:
- CLKDIV, 8'h07, value for clock divider reg 31
- ACC_CODE, 8'h00, acceptance code reg 4
- ACC_MASK, 8'hFF, acceptance mask reg 5
- BTR0, 8'h00, bus timing 0 reg 6
- BTR1, 8'h14, bus timing 1 reg 7
- OCR, 8'h1A, output control reg 8
- TIMEOUT, 16'd1024, bus-access watchdog limit in cycles (used only with the optional feature)

Ports:
- av_clk  in  1  sole clock
- av_reset_n  in  1  asynchronous active-low reset
- m_address  out  8  register address
- m_chipselect  out  1  asserted with m_read/m_write
- m_write  out  1  write strobe
- m_read  out  1  read strobe
- m_writedata  out  32  {24'h0, byte}
- m_readdata  in  32  bits [7:0] valid
- m_byteenable  out  4  constant 4'b0001 while accessing, else 0
- m_waitrequest_n  in  1  access completes in a cycle where high
- can_irq_n  in  1  controller interrupt, active low, level
- tx_valid  in  1  frame offered
- tx_ready  out  1  frame accepted when tx_valid & tx_ready
- tx_id  in  11  identifier
- tx_rtr  in  1  remote frame
- tx_dlc  in  4  data length code
- tx_data  in  64  byte0 = [63:56]
- rx_valid  out  1  frame available
- rx_ready  in  1  consumer accepts
- rx_id  out  11, rx_rtr out 1, rx_dlc out 4, rx_data out 64  received frame fields
- init_done  out  1  configuration complete
- tx_busy  out  1  frame launched, TI not yet seen
- tx_done  out  1  one-cycle pulse on TI
- bus_err  out  1  sticky watchdog error (0 without the optional feature)

Behaviour:
- Reset: all outputs 0, state INIT, step counter 0. Async reset mid-operation aborts any access immediately; init reruns from step 0.
- Access rule:
  - m_address, m_writedata, m_read/m_write and m_chipselect are held stable until the first cycle with m_waitrequest_n=1.
  - Strobes drop the next cycle.
  - Exactly one idle cycle between consecutive accesses.
  - Read data is captured from m_readdata[7:0] in the completing cycle.
- INIT writes, in order:
  - reg0=8'h01 (reset request)
  - reg31=CLKDIV
  - reg4=ACC_CODE
  - reg5=ACC_MASK
  - reg6=BTR0
  - reg7=BTR1
  - reg8=OCR
  - reg0=8'h06 (leave reset, RIE|TIE)
  - Then init_done=1 and go to IDLE.
- IDLE priority:
  1. can_irq_n=0 -> IRQ_RD.
  2. Else tx_valid & tx_ready -> TX_LOAD.
  - tx_ready = IDLE & init_done & ~tx_busy & can_irq_n; the frame is captured on the handshake.
- TX_LOAD:
  - Writes reg10=id[10:3] and reg11={id[2:0],rtr,dlc}.
  - Then writes data bytes to reg12.. for n = rtr ? 0 : min(dlc,8) bytes; dlc>8 writes 8 bytes, but the DLC field is sent unmodified.
  - Then TX_CMD writes reg1=8'h01, sets tx_busy=1 and returns to IDLE.
- IRQ_RD:
  - Reads reg3.
  - If bit1 (TI): tx_busy=0, tx_done pulses 1 cycle.
  - If bit0 (RI): go to RX_RD; else go to IDLE. Both bits set: TI handled first, same cycle, then RX.
  - Other bits are ignored.
- RX_RD:
  - Reads reg20..29 (10 reads, always).
  - Field mapping: rx_id={b20,b21[7:5]}, rx_rtr=b21[4], rx_dlc=b21[3:0], rx_data={b22..b29}.
  - Then RX_HOLD.
- RX_HOLD:
  - rx_valid=1 with fields stable until rx_ready.
  - rx_valid drops the cycle after the handshake.
  - Then RX_REL writes reg1=8'h04 and returns to IDLE. If the irq is still low, it re-enters IRQ_RD.
- Read and TX-load are never interleaved; a pending tx waits while RX is serviced.

Optional Feature:
- CAN_SEQ_TIMEOUT_EN defined:
  - A 16-bit counter runs during each access.
  - If m_waitrequest_n stays low for TIMEOUT cycles, the strobes drop, bus_err is set (sticky until reset), and the state goes to IDLE (INIT restarts at step 0 and init_done stays 0). tx_busy is cleared.
- Undefined: no counter; accesses wait indefinitely; bus_err tied 0.

Test Plan:
- Reset release, slave ack after 2 cycles each -> 8 writes in order (0:01, 31:07, 4:00, 5:FF, 6:00, 7:14, 8:1A, 0:06) with one idle cycle between, then init_done=1.
- tx id=11'h123, dlc=3, data=64'hAABBCC.. -> writes 10:24, 11:63, 12:AA, 13:BB, 14:CC, 1:01; tx_busy=1. Irq with reg3=02 -> tx_done single pulse, tx_busy=0.
- tx rtr=1, dlc=8 -> writes only 10, 11 (11 = {id[2:0],1,1000}) then 1:01. tx with dlc=4'hF -> 8 data writes.
- can_irq_n low, reg3=01, rx regs 20..29 = 24,63,AA..(8 bytes) -> rx_id=123, dlc=3, rx_valid held 5 cycles with rx_ready=0, fields stable; after the handshake, write 1:04.
- reg3=03 while tx_valid asserted -> tx_done pulse, RX drained, and only then is the tx frame accepted.
- av_reset_n low during TX_LOAD -> outputs 0 asynchronously; after release, init rerun from reg0:01. With CAN_SEQ_TIMEOUT_EN and TIMEOUT=16, waitrequest_n held 0 -> strobes drop after 16 cycles and bus_err=1.
